mc_controller: RTL
==================

// Module: mc_controller
// PURPOSE
//  Multicycle main control FSM for the RV32I core. Sits directly upstream of aludec.
//  Sequences each instruction through fetch/decode/execute/memory/writeback.
//  Drives datapath enables/muxes and the 2-bit aluop consumed by aludec.
//  Stalls on a memory ready handshake and flags illegal opcodes and memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles spent waiting for mem_ready in one memory state (>=1)
// PORTS
//  clk        in   1  system clock, all state updates on rising edge
//  reset      in   1  synchronous, active-high; forces state to FETCH
//  opcode     in   7  instr[6:0] from the instruction register
//  zero       in   1  ALU zero flag (valid in BEQ state)
//  mem_ready  in   1  memory completes the current access this cycle
//  pcwrite    out  1  PC load enable (already qualified by branch/zero)
//  irwrite    out  1  instruction register load
//  adrsrc     out  1  memory address: 0=PC, 1=ALU result register
//  memwrite   out  1  data memory write strobe
//  regwrite   out  1  register file write enable
//  alusrca    out  2  00=PC, 01=oldPC, 10=rs1
//  alusrcb    out  2  00=rs2, 01=imm, 10=const 4
//  resultsrc  out  2  00=ALUOut, 01=memory data, 10=ALU result direct
//  aluop      out  2  to aludec: 00=add, 10=decode by opcode/func3/func7
//  illegal    out  1  one-cycle pulse: unsupported opcode
//  mem_timeout out 1  one-cycle pulse: mem_ready not seen within MEM_TIMEOUT cycles
//  state_o    out  4  current state encoding (debug)
// BEHAVIOUR
//  - Moore FSM; outputs decode from the state register only, except pcwrite in BEQ (uses zero).
//  - States/encoding: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6
//    ALUWB=7 EXECI=8 BEQ=9 AUIPC=10 JAL=11 ERROR=12; 13-15 are unreachable -> FETCH.
//  - FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10; irwrite/pcwrite=mem_ready.
//    Stay in FETCH until mem_ready, then DECODE.
//  - DECODE (1 cycle; alusrca=01 alusrcb=01 aluop=00 for branch target): opcode 0000011/0100011
//    ->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BEQ; 0010111->AUIPC;
//    1101111->JAL (JAL_EN only); anything else->ERROR.
//  - MEMADR: alusrca=10 alusrcb=01 aluop=00; lw->MEMREAD, sw->MEMWRITE.
//  - MEMREAD: adrsrc=1; wait for mem_ready -> MEMWB. MEMWB: resultsrc=01 regwrite=1 -> FETCH.
//  - MEMWRITE: adrsrc=1, memwrite=1 held until mem_ready -> FETCH.
//  - EXECR: alusrca=10 alusrcb=00 aluop=10 -> ALUWB. EXECI: alusrca=10 alusrcb=01 aluop=10 -> ALUWB.
//  - ALUWB: resultsrc=00 regwrite=1 -> FETCH.
//  - BEQ: alusrca=10 alusrcb=00 aluop=10 (aludec resolves B_TYPE to sub), resultsrc=00,
//    pcwrite=zero -> FETCH.
//  - AUIPC: alusrca=01 alusrcb=01 aluop=10 -> ALUWB.
//  - ERROR: illegal=1 (or mem_timeout=1 if entered by timeout), all write enables 0 -> FETCH.
//  - Wait counter: 0 on entering FETCH/MEMREAD/MEMWRITE, +1 per stalled cycle; when count
//    reaches MEM_TIMEOUT-1 with mem_ready still 0 -> ERROR next cycle. mem_ready on that
//    same cycle wins (normal transition, no timeout). Counter saturates, never wraps.
//  - Reset: state=FETCH, counter=0, illegal=mem_timeout=0; during the reset cycle all write
//    enables (pcwrite, irwrite, memwrite, regwrite) are forced 0. Reset mid-instruction
//    abandons it; no write enable is asserted in the cycle after reset other than FETCH's.
//  - Non-write outputs in states that do not list them: 0.
// CONFIGURATION
//  JAL_EN defined: JAL state enabled: alusrca=01 alusrcb=10 aluop=00, resultsrc=00,
//    pcwrite=1 (PC <- branch target from DECODE), -> ALUWB to write rd=oldPC+4.
//  JAL_EN undefined: opcode 1101111 is illegal (DECODE -> ERROR); encoding 11 unreachable.
// TESTING
//  1 reset=1 two cycles, mem_ready=1 -> state_o=0, all enables 0 during reset, irwrite=1 after.
//  2 lw (0000011), mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 only in state 4, resultsrc=01.
//  3 beq with zero=1 then zero=0 -> pcwrite=1 in BEQ only when zero=1; aluop=10 in state 9.
//  4 sw, mem_ready low 3 cycles in MEMWRITE -> memwrite held 4 cycles, then FETCH.
//  5 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> ERROR after 4 cycles, mem_timeout pulse 1 cycle.
//  6 opcode 1101111 -> JAL_EN: states 0,1,11,7,0 pcwrite in 11; no JAL_EN: illegal pulse, state 12.

Source files
------------

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller -- multicycle main control FSM for the RV32I core.
//
// Sequences each instruction through fetch / decode / execute / memory /
// writeback. It drives the datapath enables and mux selects, plus the 2-bit
// aluop consumed by aludec. It stalls on the memory ready handshake and
// reports unsupported opcodes and memory timeouts.
//
// Memory handshake: the controller holds its address/strobe outputs in
// FETCH, MEMREAD and MEMWRITE until mem_ready is seen high at a rising
// edge. That edge completes the access. No separate request signal exists;
// being in one of those states is the request.
//
// Parameters:
//   MEM_TIMEOUT  maximum cycles spent waiting for mem_ready in one memory
//                state (>= 1)
//
// Optional feature (macro JAL_EN):
//   JAL_EN defined   : opcode 1101111 runs the JAL state.
//   JAL_EN undefined : opcode 1101111 is illegal, and encoding 11 is unreachable.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset (state -> FETCH)
//   opcode[6:0]  in   instr[6:0] from the instruction register
//   zero         in   ALU zero flag (used in BEQ)
//   mem_ready    in   memory completes the current access this cycle
//   pcwrite      out  PC load enable (already qualified by zero in BEQ)
//   irwrite      out  instruction register load
//   adrsrc       out  memory address: 0=PC, 1=ALU result register
//   memwrite     out  data memory write strobe
//   regwrite     out  register file write enable
//   alusrca[1:0] out  00=PC, 01=oldPC, 10=rs1
//   alusrcb[1:0] out  00=rs2, 01=imm, 10=const 4
//   resultsrc[1:0] out 00=ALUOut, 01=memory data, 10=ALU result direct
//   aluop[1:0]   out  00=add, 10=decode by opcode/func3/func7
//   illegal      out  one-cycle pulse: unsupported opcode
//   mem_timeout  out  one-cycle pulse: memory wait exceeded MEM_TIMEOUT
//   state_o[3:0] out  current state encoding (debug)
// ---------------------------------------------------------------------------
module mc_controller #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       irwrite,
   output logic       adrsrc,
   output logic       memwrite,
   output logic       regwrite,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] resultsrc,
   output logic [1:0] aluop,
   output logic       illegal,
   output logic       mem_timeout,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_BEQ      = 4'd9,
      S_AUIPC    = 4'd10,
      S_JAL      = 4'd11,
      S_ERROR    = 4'd12
   } state_t;

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic          to_flag;   // ERROR was entered through a memory timeout
   logic          waiting;   // stalled in a memory state this cycle
   logic          expired;   // last allowed stall cycle and still no ready

   // Raw write enables; gated with reset below so nothing writes during reset.
   logic pc_raw, ir_raw, mem_raw, reg_raw;

   assign waiting = ((state == S_FETCH) || (state == S_MEMREAD) ||
                     (state == S_MEMWRITE)) && !mem_ready;
   assign expired = waiting && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         cnt     <= '0;
         to_flag <= 1'b0;
      end else begin
         state   <= state_next;
         to_flag <= expired;
         // Any state change restarts the count, so it is zero on entry to
         // every memory state. It saturates rather than wraps.
         if (state_next != state)
            cnt <= '0;
         else if (waiting && (cnt != CNT_LAST))
            cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      state_next = S_FETCH;
      pc_raw     = 1'b0;
      ir_raw     = 1'b0;
      mem_raw    = 1'b0;
      reg_raw    = 1'b0;
      adrsrc     = 1'b0;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      resultsrc  = 2'b00;
      aluop      = 2'b00;
      illegal    = 1'b0;
      mem_timeout = 1'b0;

      case (state)
         S_FETCH: begin
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            ir_raw    = mem_ready;
            pc_raw    = mem_ready;
            // mem_ready on the final allowed cycle wins over the timeout.
            if (mem_ready)    state_next = S_DECODE;
            else if (expired) state_next = S_ERROR;
            else              state_next = S_FETCH;
         end
         S_DECODE: begin
            // Branch target oldPC + imm is computed here and latched in ALUOut.
            alusrca = 2'b01;
            alusrcb = 2'b01;
            case (opcode)
               7'b0000011,
               7'b0100011: state_next = S_MEMADR;
               7'b0110011: state_next = S_EXECR;
               7'b0010011: state_next = S_EXECI;
               7'b1100011: state_next = S_BEQ;
               7'b0010111: state_next = S_AUIPC;
`ifdef JAL_EN
               7'b1101111: state_next = S_JAL;
`endif
               default:    state_next = S_ERROR;
            endcase
         end
         S_MEMADR: begin
            alusrca    = 2'b10;
            alusrcb    = 2'b01;
            // Only lw/sw reach here; opcode bit 5 separates store from load.
            state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adrsrc = 1'b1;
            if (mem_ready)    state_next = S_MEMWB;
            else if (expired) state_next = S_ERROR;
            else              state_next = S_MEMREAD;
         end
         S_MEMWB: begin
            resultsrc = 2'b01;
            reg_raw   = 1'b1;
         end
         S_MEMWRITE: begin
            adrsrc  = 1'b1;
            mem_raw = 1'b1;
            if (mem_ready)    state_next = S_FETCH;
            else if (expired) state_next = S_ERROR;
            else              state_next = S_MEMWRITE;
         end
         S_EXECR: begin
            alusrca    = 2'b10;
            aluop      = 2'b10;
            state_next = S_ALUWB;
         end
         S_EXECI: begin
            alusrca    = 2'b10;
            alusrcb    = 2'b01;
            aluop      = 2'b10;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_raw = 1'b1;
         end
         S_BEQ: begin
            alusrca = 2'b10;
            aluop   = 2'b10;
            pc_raw  = zero;
         end
         S_AUIPC: begin
            alusrca    = 2'b01;
            alusrcb    = 2'b01;
            aluop      = 2'b10;
            state_next = S_ALUWB;
         end
`ifdef JAL_EN
         S_JAL: begin
            // PC <- branch target from DECODE; oldPC + 4 goes on to rd.
            alusrca    = 2'b01;
            alusrcb    = 2'b10;
            pc_raw     = 1'b1;
            state_next = S_ALUWB;
         end
`endif
         S_ERROR: begin
            illegal     = !to_flag;
            mem_timeout = to_flag;
         end
         default: state_next = S_FETCH;
      endcase
   end

   assign pcwrite  = pc_raw  & ~reset;
   assign irwrite  = ir_raw  & ~reset;
   assign memwrite = mem_raw & ~reset;
   assign regwrite = reg_raw & ~reset;
   assign state_o  = state;

endmodule
